// File: rtl/ul_fft_pkg.sv
// Shared definitions for the uplink FFT front end: state encoding, default
// OFDM numerology and common widths.
package ul_fft_pkg;

  localparam int unsigned UL_FFT_SIZE_DEF     = 4096;
  localparam int unsigned UL_CP_LEN_DEF       = 288;
  localparam int unsigned UL_CP_LEN_FIRST_DEF = 352;

  localparam int unsigned NUM_SYM  = 14;
  localparam int unsigned NUM_SLOT = 20;
  localparam int unsigned SYM_W    = $clog2(NUM_SYM);
  localparam int unsigned SLOT_W   = $clog2(NUM_SLOT);

  localparam int unsigned SMP_CNT_W = 13;
  localparam int unsigned ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SKIP = 2'd1,
    ST_PASS = 2'd2,
    ST_DONE = 2'd3
  } ul_state_e;

endpackage

// File: rtl/ul_sat_cnt16.sv
// 16-bit event counter that sticks at all-ones; cleared only by reset.
module ul_sat_cnt16
  import ul_fft_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 i_inc,
  output logic [ERR_CNT_W-1:0] o_cnt
);

  // Increment on each event until saturated
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_cnt <= '0;
    end else if (i_inc && (o_cnt != '1)) begin
      o_cnt <= o_cnt + ERR_CNT_W'(1);
    end
  end

endmodule

// File: rtl/ul_cp_removal.sv
// Uplink cyclic-prefix removal: drops the CP of every OFDM symbol, forwards
// exactly FFT_SIZE useful samples tagged with sop/eop and symbol/slot index,
// and flags symbols whose marker spacing does not match CP + FFT length.
module ul_cp_removal
  import ul_fft_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned FFT_SIZE     = UL_FFT_SIZE_DEF,
  parameter int unsigned CP_LEN       = UL_CP_LEN_DEF,
  parameter int unsigned CP_LEN_FIRST = UL_CP_LEN_FIRST_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 car_en,
  input  logic                 s_valid,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 sym_mrkr,
  input  logic [SYM_W-1:0]     sym_cnt,
  input  logic [SLOT_W-1:0]    slot_cnt,
  output logic                 m_valid,
  output logic [DATA_W-1:0]    m_data,
  output logic                 m_sop,
  output logic                 m_eop,
  output logic [SYM_W-1:0]     m_sym_idx,
  output logic [SLOT_W-1:0]    m_slot_idx,
  output logic                 err_short,
  output logic                 err_long,
  output logic [ERR_CNT_W-1:0] err_short_cnt,
  output logic [ERR_CNT_W-1:0] err_long_cnt
);

  ul_state_e             r_state;
  logic [SMP_CNT_W-1:0]  r_cnt;
  logic [SMP_CNT_W-1:0]  r_cp_target;
  logic [SYM_W-1:0]      r_sym;
  logic [SLOT_W-1:0]     r_slot;
  logic                  r_long_seen;

  logic [SMP_CNT_W-1:0]  w_cp_sel;
  logic [SMP_CNT_W-1:0]  w_cnt_inc;
  logic                  w_cp_one_now;

  // CP length for the symbol announced by the current marker
  assign w_cp_sel     = (sym_cnt == '0) ? SMP_CNT_W'(CP_LEN_FIRST) : SMP_CNT_W'(CP_LEN);
  assign w_cnt_inc    = r_cnt + SMP_CNT_W'(1);
  // A one-sample CP is fully consumed by the marker sample itself
  assign w_cp_one_now = s_valid && (w_cp_sel == SMP_CNT_W'(1));

  // Symbol sequencing, sample forwarding and error pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_cp_target <= '0;
      r_sym       <= '0;
      r_slot      <= '0;
      r_long_seen <= 1'b0;
      m_valid     <= 1'b0;
      m_data      <= '0;
      m_sop       <= 1'b0;
      m_eop       <= 1'b0;
      m_sym_idx   <= '0;
      m_slot_idx  <= '0;
      err_short   <= 1'b0;
      err_long    <= 1'b0;
    end else begin
      m_valid   <= 1'b0;
      m_sop     <= 1'b0;
      m_eop     <= 1'b0;
      err_short <= 1'b0;
      err_long  <= 1'b0;

      if (!car_en) begin
        // Carrier off: abandon any block silently
        r_state     <= ST_IDLE;
        r_cnt       <= '0;
        r_long_seen <= 1'b0;
      end else if (sym_mrkr) begin
        // Marker wins over everything, including an eop-bearing sample
        r_sym       <= sym_cnt;
        r_slot      <= slot_cnt;
        r_cp_target <= w_cp_sel;
        r_long_seen <= 1'b0;
        err_short   <= (r_state == ST_PASS);
        if (w_cp_one_now) begin
          r_cnt   <= '0;
          r_state <= ST_PASS;
        end else begin
          r_cnt   <= s_valid ? SMP_CNT_W'(1) : '0;
          r_state <= ST_SKIP;
        end
      end else if (s_valid) begin
        case (r_state)
          ST_SKIP: begin
            if (w_cnt_inc == r_cp_target) begin
              r_cnt   <= '0;
              r_state <= ST_PASS;
            end else begin
              r_cnt <= w_cnt_inc;
            end
          end
          ST_PASS: begin
            m_valid <= 1'b1;
            m_data  <= s_data;
            m_sop   <= (r_cnt == '0);
            m_eop   <= (r_cnt == SMP_CNT_W'(FFT_SIZE - 1));
            r_cnt   <= w_cnt_inc;
            if (r_cnt == '0) begin
              m_sym_idx  <= r_sym;
              m_slot_idx <= r_slot;
            end
            if (r_cnt == SMP_CNT_W'(FFT_SIZE - 1)) begin
              r_state <= ST_DONE;
            end
          end
          ST_DONE: begin
            if (!r_long_seen) begin
              err_long    <= 1'b1;
              r_long_seen <= 1'b1;
            end
          end
          ST_IDLE: ;
          default: ;
        endcase
      end
    end
  end

  ul_sat_cnt16 u_short_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (err_short),
    .o_cnt   (err_short_cnt)
  );

  ul_sat_cnt16 u_long_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (err_long),
    .o_cnt   (err_long_cnt)
  );

endmodule
